uart_tx_sched: RTL and testbench

//   Shares one uart_tx serializer between N_REQ requesters, each submitting
//   a 1-4 byte word. Arbitration is round-robin. The block sequences the

---
 rtl/uart_tx_sched.sv | 119 +++++++++++
 tb/tb_uart_tx_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx between N_REQ requesters.
// Each accepted 1-4 byte word is sent MSB-first, one byte per UART frame.
module uart_tx_sched #(
  parameter int N_REQ = 2
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic [N_REQ-1:0]     i_Req_Valid,
  input  logic [32*N_REQ-1:0]  i_Req_Data,
  input  logic [2*N_REQ-1:0]   i_Req_Len,
  output logic [N_REQ-1:0]     o_Req_Ready,
  output logic [2:0]           o_Owner,
  output logic                 o_Busy,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

  state_t      state_reg;
  logic [1:0]  count_reg;
  logic [31:0] word_reg;

  // Requester buses padded to the 8-requester maximum so a 3-bit index always fits.
  logic [7:0]   valid_pad;
  logic [255:0] data_pad;
  logic [15:0]  len_pad;

  assign valid_pad = 8'(i_Req_Valid);
  assign data_pad  = 256'(i_Req_Data);
  assign len_pad   = 16'(i_Req_Len);

  // cand_idx[i] is the requester checked at priority position i (0 = highest).
  logic [2:0] cand_idx [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [3:0] sum;
      assign sum           = {1'b0, o_Owner} + 4'(gi + 1);
      assign cand_idx[gi]  = (sum >= 4'(N_REQ)) ? 3'(sum - 4'(N_REQ)) : sum[2:0];
    end
  endgenerate

  logic        grant_found;
  logic [2:0]  grant_idx;
  logic [7:0]  grant_onehot;
  logic [31:0] grant_data;
  logic [1:0]  grant_len;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (valid_pad[cand_idx[i]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[i];
      end
    end
  end

  assign grant_onehot = 8'd1 << grant_idx;
  assign grant_data   = data_pad[{grant_idx, 5'd0} +: 32];
  assign grant_len    = len_pad[{grant_idx, 1'b0} +: 2];

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      word_reg    <= '0;
      o_Req_Ready <= '0;
      o_Owner     <= 3'(N_REQ - 1);
      o_Busy      <= 1'b0;
      o_Tx_DV     <= 1'b0;
      o_Tx_Byte   <= '0;
    end else begin
      o_Req_Ready <= '0;
      o_Tx_DV     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            word_reg    <= grant_data;
            count_reg   <= grant_len;
            o_Owner     <= grant_idx;
            o_Req_Ready <= grant_onehot[N_REQ-1:0];
            o_Busy      <= 1'b1;
            state_reg   <= SEND;
          end
        end
        SEND: begin
          // Done is also checked so a frame's cleanup cycle is never overrun.
          if (!i_Tx_Active && !i_Tx_Done) begin
            o_Tx_DV   <= 1'b1;
            o_Tx_Byte <= word_reg[{count_reg, 3'd0} +: 8];
            state_reg <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (i_Tx_Done) begin
            if (count_reg == 2'd0) begin
              o_Busy    <= 1'b0;
              state_reg <= IDLE;
            end else begin
              count_reg <= count_reg - 2'd1;
              state_reg <= SEND;
            end
          end
        end
        default: begin
          o_Busy    <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a behavioural uart_tx (4 clocks/bit)
// and a line decoder that recovers the transmitted bytes.
module tb_uart_tx_sched;

  localparam int N_REQ = 2;
  localparam int CPB   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [63:0] req_data  = '0;
  logic [3:0]  req_len   = '0;
  logic [1:0]  req_ready;
  logic [2:0]  owner;
  logic        busy;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_active = 1'b0;
  logic        tx_done   = 1'b0;
  logic        tx_line   = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_sched #(.N_REQ(N_REQ)) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Req_Valid (req_valid),
    .i_Req_Data  (req_data),
    .i_Req_Len   (req_len),
    .o_Req_Ready (req_ready),
    .o_Owner     (owner),
    .o_Busy      (busy),
    .o_Tx_DV     (tx_dv),
    .o_Tx_Byte   (tx_byte),
    .i_Tx_Active (tx_active),
    .i_Tx_Done   (tx_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // uart_tx model: no reset, Done high for 2 cycles, DV ignored unless idle.
  int         tx_phase = 0;
  int         tcnt = 0;
  logic [9:0] tx_frame = '0;

  always @(posedge clk) begin
    case (tx_phase)
      0: if (tx_dv) begin
        tx_frame  <= {1'b1, tx_byte, 1'b0};
        tcnt      <= 0;
        tx_active <= 1'b1;
        tx_line   <= 1'b0;
        tx_phase  <= 1;
      end
      1: if (tcnt == 10*CPB - 1) begin
        tx_active <= 1'b0;
        tx_done   <= 1'b1;
        tx_line   <= 1'b1;
        tx_phase  <= 2;
      end else begin
        tcnt    <= tcnt + 1;
        tx_line <= tx_frame[(tcnt + 1) / CPB];
      end
      2: tx_phase <= 3;
      default: begin
        tx_done  <= 1'b0;
        tx_phase <= 0;
      end
    endcase
  end

  // Line decoder: samples each bit near its middle, LSB first.
  int         rx_cnt = 0;
  logic       rx_busy = 1'b0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_q[$];

  always @(posedge clk) begin
    if (!rx_busy) begin
      if (tx_line == 1'b0) begin
        rx_busy <= 1'b1;
        rx_cnt  <= 0;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt == 9*CPB + 1) begin
        rx_busy <= 1'b0;
        rx_q.push_back(rx_sh);
      end else if (rx_cnt > 1 && (rx_cnt % CPB) == 1) begin
        rx_sh <= {tx_line, rx_sh[7:1]};
      end
    end
  end

  // Protocol monitor: every DV must hit an idle uart and never repeat back to back.
  logic prev_dv = 1'b0;
  int   dv_count = 0;
  int   grant_q[$];

  always @(negedge clk) begin
    if (tx_dv === 1'b1) begin
      dv_count++;
      chk("dv_uart_idle", {30'd0, tx_active, tx_done}, 32'd0);
      chk("dv_gap", {31'd0, prev_dv}, 32'd0);
    end
    prev_dv = tx_dv;
    if (|req_ready) begin
      chk("ready_onehot", {31'd0, $onehot(req_ready)}, 32'd1);
      grant_q.push_back(req_ready[1] ? 1 : 0);
    end
  end

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 2000 && busy; k++) @(negedge clk);
    chk({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic start_test(input string tag);
    for (int k = 0; k < 200 && tx_phase != 0; k++) @(negedge clk);
    chk({tag, "_uart_idle"}, 32'(tx_phase), 32'd0);
    rx_q.delete();
    grant_q.delete();
    dv_count = 0;
  endtask

  task automatic check_rx(input string tag, input logic [31:0] exp, input int n);
    logic [7:0] got;
    chk({tag, "_rx_count"}, 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      chk($sformatf("%s_rx_byte%0d", tag, i), {24'd0, got}, {24'd0, exp[(n-1-i)*8 +: 8]});
    end
  endtask

  task automatic check_grants(input string tag, input logic [3:0] exp, input int n);
    int got;
    chk({tag, "_grant_count"}, 32'(grant_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      got = (i < grant_q.size()) ? grant_q[i] : -1;
      chk($sformatf("%s_grant%0d", tag, i), 32'(got), {31'd0, exp[n-1-i]});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_dv",    {31'd0, tx_dv},     32'd0);
    chk("rst_byte",  {24'd0, tx_byte},   32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_owner", {29'd0, owner},     32'd1);
    rst = 1'b0;

    // 1: 4-byte word, latency and MSB-first order
    start_test("t1");
    req_data[31:0] = 32'hDEADBEEF;
    req_len[1:0]   = 2'd3;
    req_valid      = 2'b01;
    @(negedge clk);
    chk("t1_ready",  {30'd0, req_ready}, 32'd1);
    chk("t1_owner",  {29'd0, owner},     32'd0);
    chk("t1_busy",   {31'd0, busy},      32'd1);
    chk("t1_no_dv",  {31'd0, tx_dv},     32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    chk("t1_dv",     {31'd0, tx_dv},     32'd1);
    chk("t1_byte",   {24'd0, tx_byte},   32'hDE);
    wait_idle("t1");
    chk("t1_dv_count", 32'(dv_count), 32'd4);
    check_rx("t1", 32'hDEADBEEF, 4);

    // 2: simultaneous valids after reset, requester 0 wins first
    do_reset();
    start_test("t2");
    req_data  = {32'h0000_00B2, 32'h0000_00A1};
    req_len   = 4'b0000;
    req_valid = 2'b11;
    @(negedge clk);
    chk("t2_ready0", {30'd0, req_ready}, 32'd1);
    req_valid[0] = 1'b0;
    for (int k = 0; k < 2000 && !req_ready[1]; k++) @(negedge clk);
    chk("t2_ready1", {30'd0, req_ready}, 32'd2);
    req_valid[1] = 1'b0;
    wait_idle("t2");
    check_grants("t2", 4'b0001, 2);
    check_rx("t2", 32'h0000A1B2, 2);

    // 3: requester 0 held continuously, grants must alternate
    do_reset();
    start_test("t3");
    req_data  = {32'h0000_0022, 32'h0000_0011};
    req_len   = 4'b0000;
    req_valid = 2'b11;
    for (int k = 0; k < 3000 && grant_q.size() < 4; k++) @(negedge clk);
    req_valid = 2'b00;
    wait_idle("t3");
    check_grants("t3", 4'b0101, 4);
    check_rx("t3", 32'h11221122, 4);

    // 4: 2-byte word
    do_reset();
    start_test("t4");
    req_data[31:0] = 32'h0000_1234;
    req_len[1:0]   = 2'd1;
    req_valid      = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    wait_idle("t4");
    chk("t4_dv_count", 32'(dv_count), 32'd2);
    check_rx("t4", 32'h00001234, 2);

    // 5: reset one cycle after the 2nd DV; the in-flight frame still completes
    do_reset();
    start_test("t5");
    req_data[31:0] = 32'h01020304;
    req_len[1:0]   = 2'd3;
    req_valid      = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    seen = 0;
    for (int k = 0; k < 2000 && seen < 2; k++) begin
      @(negedge clk);
      if (tx_dv) seen++;
    end
    chk("t5_two_dv", 32'(seen), 32'd2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_busy",  {31'd0, busy},      32'd0);
    chk("t5_rst_dv",    {31'd0, tx_dv},     32'd0);
    chk("t5_rst_ready", {30'd0, req_ready}, 32'd0);
    chk("t5_rst_byte",  {24'd0, tx_byte},   32'd0);
    chk("t5_rst_owner", {29'd0, owner},     32'd1);
    rst = 1'b0;
    req_data[63:32] = 32'h0000_0055;
    req_len[3:2]    = 2'd0;
    req_valid       = 2'b10;
    @(negedge clk);
    chk("t5_ready1", {30'd0, req_ready}, 32'd2);
    req_valid = 2'b00;
    @(negedge clk);
    chk("t5_dv_held", {31'd0, tx_dv}, 32'd0);
    wait_idle("t5");
    chk("t5_dv_count", 32'(dv_count), 32'd3);
    check_rx("t5", 32'h00010255, 3);

    // 6: only requester 1 valid, wrap-around search from owner 1
    do_reset();
    start_test("t6");
    req_data[63:32] = 32'h0000_0077;
    req_len[3:2]    = 2'd0;
    req_valid       = 2'b10;
    @(negedge clk);
    chk("t6_ready", {30'd0, req_ready}, 32'd2);
    chk("t6_owner", {29'd0, owner},     32'd1);
    req_valid = 2'b00;
    wait_idle("t6");
    check_rx("t6", 32'h00000077, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
